// File: rtl/mdu_if.sv
// Operand, control and result bundle between the E stage and the multiply/divide unit.
interface mdu_if;
  logic [31:0] R1;
  logic [31:0] R2;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;

  modport master (
    output R1, R2, MDUOp, Start,
    input  Busy, HI, LO, MDUOut
  );

  modport slave (
    input  R1, R2, MDUOp, Start,
    output Busy, HI, LO, MDUOut
  );
endinterface

// File: rtl/mdu.sv
// Fixed-latency multiply/divide unit owning HI/LO; result is computed at accept and
// committed when the busy countdown expires.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_pend_hi_p1;
  logic [31:0]        r_pend_lo_p1;
  logic               r_pend_wr_p1;

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_accept;
  logic               w_done;
  logic signed [63:0] w_a_x;
  logic signed [63:0] w_b_x;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic [63:0]        w_result;

  // Signed divide via magnitudes: truncates toward zero, remainder follows the
  // dividend, and 0x80000000 / -1 wraps to 0x80000000 without overflow traps.
  function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic [31:0] a_mag, b_mag, q_mag, r_mag, q, r;
    a_mag = a[31] ? (~a + 32'd1) : a;
    b_mag = b[31] ? (~b + 32'd1) : b;
    if (b_mag == 32'd0) b_mag = 32'd1;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    q = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    r = a[31] ? (~r_mag + 32'd1) : r_mag;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    logic [31:0] d;
    d = (b == 32'd0) ? 32'd1 : b;
    return {a % d, a / d};
  endfunction

  assign w_is_mul = (bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU);
  assign w_is_div = (bus.MDUOp == OP_DIV)  || (bus.MDUOp == OP_DIVU);
  assign w_accept = (r_state == S_IDLE) && bus.Start && (w_is_mul || w_is_div);

  assign w_a_x    = {{32{bus.R1[31]}}, bus.R1};
  assign w_b_x    = {{32{bus.R2[31]}}, bus.R2};
  assign w_prod_s = w_a_x * w_b_x;
  assign w_prod_u = {32'd0, bus.R1} * {32'd0, bus.R2};

  always_comb begin
    w_result = div_unsigned(bus.R1, bus.R2);
    case (bus.MDUOp)
      OP_MULT:  w_result = w_prod_s;
      OP_MULTU: w_result = w_prod_u;
      OP_DIV:   w_result = div_signed(bus.R1, bus.R2);
      default:  w_result = div_unsigned(bus.R1, bus.R2);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p0 -> p1: control state, countdown and architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_pend_wr_p1 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt        <= w_is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        r_pend_wr_p1 <= !(w_is_div && (bus.R2 == 32'd0));
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_done && r_pend_wr_p1) begin
        r_hi <= r_pend_hi_p1;
        r_lo <= r_pend_lo_p1;
      end else if ((r_state == S_IDLE) && !w_accept) begin
        if (bus.MDUOp == OP_MTHI) r_hi <= bus.R1;
        if (bus.MDUOp == OP_MTLO) r_lo <= bus.R1;
      end
    end
  end

  // Stage p0 -> p1: pending result captured from the operands at accept
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pend_hi_p1 <= w_result[63:32];
      r_pend_lo_p1 <= w_result[31:0];
    end
  end

  assign bus.Busy   = (r_state == S_BUSY);
  assign bus.HI     = r_hi;
  assign bus.LO     = r_lo;
  assign bus.MDUOut = (bus.MDUOp == OP_MFHI) ? r_hi :
                      (bus.MDUOp == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the E stage of the five-stage pipeline, alongside the single-cycle ALU. It executes mult/multu/div/divu with a fixed cycle latency and owns the architectural HI/LO registers. It serves mfhi/mflo reads and mthi/mtlo writes. It exports Busy so hazard logic can stall dependent instructions in D.

## Interface
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (≥1)
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (≥1)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- R1  input  32  rs operand (forwarded value)
- R2  input  32  rt operand (forwarded value)
- MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none
- Start  input  1  E-stage instruction is mult/multu/div/divu this cycle
- Busy  output  1  operation in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register
- MDUOut  output  32  mfhi → HI, mflo → LO, else 0 (combinational)

## Operation
- **Reset:** at a clk edge with reset=1, HI=0, LO=0, Busy=0, counter=0, and any pending result is discarded. This includes reset mid-operation.
- **Idle state:** Busy=0.
- **Accepting a start:** a start is accepted at an edge when Start=1, Busy=0 and MDUOp is in 1..4.
  - At accept, compute the 64-bit result from R1/R2 into internal pending HI/LO registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Set Busy=1.
- **Start with MDUOp outside 1..4:** ignored.
- **Busy state:**
  - Each edge decrements the counter.
  - At the edge where the counter goes 1→0: HI/LO ← pending values and Busy←0.
  - Start and mthi/mtlo are ignored while Busy=1; stall logic guarantees they do not occur.
- **mult:** {HI,LO} = $signed(R1)*$signed(R2), full 64 bits.
- **multu:** {HI,LO} = unsigned R1*R2.
- **div:**
  - LO = signed quotient, truncated toward zero.
  - HI = remainder, which takes the sign of the dividend R1.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **divu:** LO = R1/R2, HI = R1%R2, both unsigned.
- **Divide by zero (div/divu with R2=0):** the full DIV_CYCLES still elapse and HI/LO are left unchanged at completion.
- **mthi / mtlo:** when Busy=0 and no start is accepted, HI←R1 (mthi) or LO←R1 (mtlo) at the edge.
- **mfhi / mflo:** MDUOut returns HI or LO combinationally. During Busy, the old values are returned; hazard logic prevents this case.
- **Operand capture:** operands are sampled only at the accept edge. Later changes on R1/R2 do not affect the result.

## Timing
- Start asserted in cycle k, accepted at the end of k.
- Busy is high in cycles k+1 .. k+N, where N is MULT_CYCLES or DIV_CYCLES.
- HI/LO take the new values at the end of cycle k+N and are visible from cycle k+N+1.
- Busy is registered and not combinationally dependent on Start. Hazard logic must stall on (Start | Busy).
- Back-to-back operations: a new Start in cycle k+N+1 is accepted. A Start in cycle k+N, while Busy=1, is ignored.
- mthi/mtlo have a latency of 1 edge. An mfhi in the next cycle sees the new value.
- Reset has priority over everything else. Reset asserted in any Busy cycle returns the unit to idle at that edge, with no HI/LO write.

## Test plan
- **Reset:** reset for 2 cycles → HI=0, LO=0, Busy=0, MDUOut=0.
- **mult:** mult R1=0xFFFFFFFE (-2), R2=3 with Start for 1 cycle → Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat as multu → HI=0x00000002, LO=0xFFFFFFFA.
- **div:** div R1=-7 (0xFFFFFFF9), R2=2 → after 10 Busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **divu and overflow:** divu with the same operands → LO=0x7FFFFFFC, HI=0x00000001. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero and ignored inputs:** mthi R1=0x1234, mtlo R1=0x5678, then div by R2=0 → Busy for 10 cycles, HI=0x1234, LO=0x5678 unchanged. While Busy, a Start and an mtlo are ignored and R1 toggles with no effect.
- **Reset mid-operation:** reset in the 3rd Busy cycle of a mult → Busy=0 and HI=LO=0 next cycle, no late write. A new mult started right after reset completes normally.
